// File: rtl/sort_scheduler.sv
// Round-robin front end for a shared, non-stallable 8-lane sorting pipeline.
// Tracks jobs with a valid/ID shift register and buffers results in a credit-limited FIFO.
module sort_scheduler #(
    parameter int DATA_W     = 32,
    parameter int N_REQ      = 2,
    parameter int ID_W       = 1,
    parameter int LAT        = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*8*DATA_W-1:0] i_req_data,
    output logic [8*DATA_W-1:0]       o_sort_data,
    input  logic [8*DATA_W-1:0]       i_sort_data,
    output logic                      o_res_valid,
    input  logic                      i_res_ready,
    output logic [8*DATA_W-1:0]       o_res_data,
    output logic [ID_W-1:0]           o_res_id,
    output logic                      o_busy
);

    localparam int JOB_W = 8 * DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CNT_W-1:0] r_used;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [LAT-1:0]   r_sr_valid;
    logic [ID_W-1:0]  r_sr_id [LAT];

    logic [JOB_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]  r_mem_id   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_can_issue;
    logic             w_hit_hi;
    logic             w_hit_lo;
    int               w_sel_hi;
    int               w_sel_lo;
    int               w_sel;
    logic             w_issue;
    logic [N_REQ-1:0] w_grant;
    logic [JOB_W-1:0] w_sort_data;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_push;
    logic             w_pop;

    // A pop in the same cycle does not free a credit until the next cycle.
    assign w_can_issue = !i_rst && (r_used < CNT_W'(FIFO_DEPTH));

    // NOTE: combinational logic uses blocking assignments with a default for every
    // output first, so later loop iterations see earlier results and no latch is inferred.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_sel_hi = 0;
        w_sel_lo = 0;
        // Descending scan leaves the lowest matching index in each half.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                if (k >= int'(r_rr_ptr)) begin
                    w_hit_hi = 1'b1;
                    w_sel_hi = k;
                end else begin
                    w_hit_lo = 1'b1;
                    w_sel_lo = k;
                end
            end
        end
        w_issue = w_can_issue && (w_hit_hi || w_hit_lo);
        w_sel   = w_hit_hi ? w_sel_hi : w_sel_lo;

        w_grant     = '0;
        w_sort_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_issue && (k == w_sel)) begin
                w_grant[k]  = 1'b1;
                w_sort_data = i_req_data[k*JOB_W +: JOB_W];
            end
        end
        w_grant_id = ID_W'(w_sel);
        w_next_ptr = (w_sel == N_REQ - 1) ? '0 : ID_W'(w_sel + 1);
    end

    assign o_req_ready = w_grant;
    assign o_sort_data = w_sort_data;

    assign w_push = r_sr_valid[LAT-1];
    assign w_pop  = o_res_valid && i_res_ready;

    // NOTE: sequential state uses non-blocking assignments; the FIFO storage is in the
    // async reset so a discarded job can never reappear at the head after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_used     <= '0;
            r_rr_ptr   <= '0;
            r_sr_valid <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_id[i]   <= '0;
            end
        end else begin
            r_sr_valid[0] <= w_issue;
            for (int i = 1; i < LAT; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
            end

            if (w_issue) begin
                r_rr_ptr <= w_next_ptr;
            end

            unique case ({w_issue, w_pop})
                2'b10:   r_used <= r_used + CNT_W'(1);
                2'b01:   r_used <= r_used - CNT_W'(1);
                default: r_used <= r_used;
            endcase

            if (w_push) begin
                r_mem_data[r_wr_ptr] <= i_sort_data;
                r_mem_id[r_wr_ptr]   <= r_sr_id[LAT-1];
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Job IDs are only meaningful alongside their valid bit, so they need no reset.
    always_ff @(posedge i_clk) begin
        r_sr_id[0] <= w_grant_id;
        for (int i = 1; i < LAT; i++) begin
            r_sr_id[i] <= r_sr_id[i-1];
        end
    end

    assign o_res_valid = (r_count != '0);
    assign o_res_data  = o_res_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_res_id    = o_res_valid ? r_mem_id[r_rd_ptr] : '0;
    assign o_busy      = (r_used != '0);

endmodule
